// File: rtl/chan_pkt_pkg.sv
// chan_pkt_pkg: shared state encoding and frame geometry for the
// chan_pkt transmitter, receiver and checker.
package chan_pkt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD    = 2'd1,
      ST_LOAD  = 2'd2,
      ST_SHIFT = 2'd3
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int id_width(input int n_ch);
      return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
   endfunction

   // Frame: start, id (LSB first), data (LSB first), parity, stop
   localparam int START_OFS = 0;
   localparam int ID_OFS    = 1;

   function automatic int data_ofs(input int id_w);
      return ID_OFS + id_w;
   endfunction

   function automatic int par_ofs(input int id_w, input int data_w);
      return data_ofs(id_w) + data_w;
   endfunction

   function automatic int stop_ofs(input int id_w, input int data_w);
      return par_ofs(id_w, data_w) + 1;
   endfunction

   function automatic int frame_bits(input int id_w, input int data_w);
      return stop_ofs(id_w, data_w) + 1;
   endfunction

endpackage

// File: rtl/chan_pkt_tx_rr_arbiter.sv
// rr_arbiter: combinational round-robin / fixed-priority winner select.
// The pointer is owned by the caller; this block only searches.
module rr_arbiter
   import chan_pkt_pkg::*;
#(
   parameter int N_CH = 3,
   parameter int ID_W = 2
) (
   input  logic [N_CH-1:0] elig_i,
   input  logic            prio_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [ID_W-1:0] win_o,
   output logic            valid_o
);

   logic            hi_v;
   logic            lo_v;
   logic [ID_W-1:0] hi_w;
   logic [ID_W-1:0] lo_w;

   // hi: lowest eligible above ptr; lo: lowest eligible at or below ptr
   always_comb begin
      hi_v = 1'b0;
      lo_v = 1'b0;
      hi_w = '0;
      lo_w = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (elig_i[i]) begin
            if (i > int'(ptr_i)) begin
               hi_v = 1'b1;
               hi_w = ID_W'(i);
            end else begin
               lo_v = 1'b1;
               lo_w = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      win_o = '0;
      if (prio_i) win_o = lo_v ? lo_w : hi_w;
      else        win_o = hi_v ? hi_w : lo_w;
   end

   assign valid_o = |elig_i;

endmodule

// File: rtl/chan_pkt_tx.sv
// chan_pkt_tx: arbitrates N FIFOs, pops one word and sends it as a
// framed, even-parity serial packet on tx.
module chan_pkt_tx
   import chan_pkt_pkg::*;
#(
   parameter int N_CH    = 3,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 8,
   parameter int THRESH  = 1,
   parameter int BIT_DIV = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     prio_mode,
   input  logic [N_CH*CNT_W-1:0]    ch_cnt,
   input  logic [N_CH*DATA_W-1:0]   ch_dat,
   output logic [N_CH-1:0]          ch_rd_en,
   output logic                     tx,
   output logic                     tx_busy,
   output logic [15:0]              frm_cnt
);

   localparam int ID_W  = id_width(N_CH);
   localparam int F     = frame_bits(ID_W, DATA_W);
   localparam int D_OFS = data_ofs(ID_W);
   localparam int P_OFS = par_ofs(ID_W, DATA_W);
   localparam int S_OFS = stop_ofs(ID_W, DATA_W);
   localparam int BC_W  = clog2(F);
   localparam int DV_W  = 8;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N_CH-1:0]   rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic [F-1:0]      sh_q, sh_d;
   logic [BC_W-1:0]   bit_q, bit_d;
   logic [DV_W-1:0]   div_q, div_d;
   logic [15:0]       frm_q, frm_d;

   logic [N_CH-1:0]   elig;
   logic [ID_W-1:0]   win;
   logic              win_v;
   logic              launch;
   logic              bit_end;
   logic              last_bit;
   logic [DATA_W-1:0] word;
   logic [F-1:0]      frame;

   always_comb begin
      elig = '0;
      for (int i = 0; i < N_CH; i++)
         elig[i] = ch_cnt[i*CNT_W +: CNT_W] >= CNT_W'(THRESH);
   end

   rr_arbiter #(
      .N_CH (N_CH),
      .ID_W (ID_W)
   ) u_arb (
      .elig_i  (elig),
      .prio_i  (prio_mode),
      .ptr_i   (rr_ptr_q),
      .win_o   (win),
      .valid_o (win_v)
   );

   always_comb begin
      word = '0;
      for (int i = 0; i < N_CH; i++)
         if (grant_q == ID_W'(i)) word = ch_dat[i*DATA_W +: DATA_W];
   end

   always_comb begin
      frame                  = '1;
      frame[START_OFS]       = 1'b0;
      frame[ID_OFS +: ID_W]  = grant_q;
      frame[D_OFS +: DATA_W] = word;
      frame[P_OFS]           = ^{grant_q, word};
      frame[S_OFS]           = 1'b1;
   end

   assign launch   = start && win_v;
   assign bit_end  = div_q == DV_W'(BIT_DIV - 1);
   assign last_bit = bit_q == BC_W'(F - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (launch) state_d = ST_RD;
         ST_RD:    state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: if (bit_end && last_bit) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      rd_en_d  = '0;
      busy_d   = busy_q;
      sh_d     = sh_q;
      bit_d    = bit_q;
      div_d    = div_q;
      frm_d    = frm_q;
      unique case (state_q)
         ST_IDLE: begin
            if (launch) begin
               grant_d  = win;
               rr_ptr_d = win;
               rd_en_d  = N_CH'(1) << win;
               busy_d   = 1'b1;
            end
         end
         ST_RD: begin
         end
         ST_LOAD: begin
            sh_d  = frame;
            bit_d = '0;
            div_d = '0;
         end
         ST_SHIFT: begin
            if (bit_end) begin
               div_d = '0;
               sh_d  = {1'b1, sh_q[F-1:1]};
               if (last_bit) begin
                  busy_d = 1'b0;
                  frm_d  = frm_q + 16'd1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // sh_q idles all ones so tx rests high between frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q  <= '0;
         rr_ptr_q <= ID_W'(N_CH - 1);
         rd_en_q  <= '0;
         busy_q   <= 1'b0;
         sh_q     <= '1;
         bit_q    <= '0;
         div_q    <= '0;
         frm_q    <= '0;
      end else begin
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         rd_en_q  <= rd_en_d;
         busy_q   <= busy_d;
         sh_q     <= sh_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         frm_q    <= frm_d;
      end
   end

   assign ch_rd_en = rd_en_q;
   assign tx       = sh_q[0];
   assign tx_busy  = busy_q;
   assign frm_cnt  = frm_q;

endmodule

// File: tb/tb_chan_pkt_tx.sv
// tb_chan_pkt_tx: two transmitters (div 1/thresh 1 and div 4/thresh 3)
// fed by bench FIFOs and compared against a packet-schedule model.
module tb_chan_pkt_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  start_s = '0;
   logic [1:0]  prio_s = '0;
   logic [47:0] cnt_s = '0;
   logic [47:0] dat_s = '0;
   logic [5:0]  rd_s;
   logic [1:0]  tx_s;
   logic [1:0]  busy_s;
   logic [31:0] frm_s;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  fq[6][$];

   int          m_t[2]   = '{0, 0};
   logic [1:0]  m_win[2] = '{2'd0, 2'd0};
   logic [7:0]  m_word[2] = '{8'd0, 8'd0};
   logic [1:0]  m_rr[2]  = '{2'd2, 2'd2};
   logic [15:0] m_frm[2] = '{16'd0, 16'd0};

   localparam int F = 13;

   always #5 clk = ~clk;

   chan_pkt_tx #(
      .N_CH (3), .DATA_W (8), .CNT_W (8), .THRESH (1), .BIT_DIV (1)
   ) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s[0]),
      .prio_mode (prio_s[0]),
      .ch_cnt    (cnt_s[23:0]),
      .ch_dat    (dat_s[23:0]),
      .ch_rd_en  (rd_s[2:0]),
      .tx        (tx_s[0]),
      .tx_busy   (busy_s[0]),
      .frm_cnt   (frm_s[15:0])
   );

   chan_pkt_tx #(
      .N_CH (3), .DATA_W (8), .CNT_W (8), .THRESH (3), .BIT_DIV (4)
   ) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s[1]),
      .prio_mode (prio_s[1]),
      .ch_cnt    (cnt_s[47:24]),
      .ch_dat    (dat_s[47:24]),
      .ch_rd_en  (rd_s[5:3]),
      .tx        (tx_s[1]),
      .tx_busy   (busy_s[1]),
      .frm_cnt   (frm_s[31:16])
   );

   function automatic int div_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic int thr_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic elig(input int k, input int i);
      return fq[k*3 + i].size() >= thr_of(k);
   endfunction

   function automatic int pick(input int k);
      int w;
      int c;
      w = -1;
      if (prio_s[k]) begin
         for (int i = 0; i < 3; i++)
            if (w < 0 && elig(k, i)) w = i;
      end else begin
         for (int o = 1; o <= 3; o++) begin
            c = (int'(m_rr[k]) + o) % 3;
            if (w < 0 && elig(k, c)) w = c;
         end
      end
      return w;
   endfunction

   function automatic logic fbit(input logic [1:0] w, input logic [7:0] d,
                                 input int j);
      if (j == 0)  return 1'b0;
      if (j <= 2)  return w[j-1];
      if (j <= 10) return d[j-3];
      if (j == 11) return ^{w, d};
      return 1'b1;
   endfunction

   function automatic logic exp_tx(input int k);
      if (m_t[k] < 3) return 1'b1;
      return fbit(m_win[k], m_word[k], (m_t[k] - 3) / div_of(k));
   endfunction

   function automatic logic [2:0] exp_rd(input int k);
      return (m_t[k] == 1) ? (3'b001 << m_win[k]) : 3'b000;
   endfunction

   // Packet schedule: m_t counts cycles since the grant, 0 means idle
   always @(posedge clk or posedge rst) begin : mdl
      int t;
      int w;
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_t[k]   <= 0;
            m_frm[k] <= 16'd0;
            m_rr[k]  <= 2'd2;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_t[k] != 0) begin
               t = m_t[k] + 1;
               if (t == 3 + F * div_of(k)) begin
                  m_t[k]   <= 0;
                  m_frm[k] <= m_frm[k] + 16'd1;
               end else begin
                  m_t[k] <= t;
               end
            end else if (start_s[k]) begin
               w = pick(k);
               if (w >= 0) begin
                  m_t[k]    <= 1;
                  m_win[k]  <= 2'(w);
                  m_rr[k]   <= 2'(w);
                  m_word[k] <= fq[k*3 + w][0];
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      for (int j = 0; j < 6; j++)
         cnt_s[j*8 +: 8] = 8'(fq[j].size());
   endtask

   task automatic push(input int k, input int i, input logic [7:0] v);
      if (fq[k*3 + i].size() < 200) fq[k*3 + i].push_back(v);
      drive();
   endtask

   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("tx%0d", k), 32'(tx_s[k]), 32'(exp_tx(k)));
         chk($sformatf("busy%0d", k), 32'(busy_s[k]), 32'(m_t[k] != 0));
         chk($sformatf("rd%0d", k), 32'(rd_s[k*3 +: 3]), 32'(exp_rd(k)));
         chk($sformatf("frm%0d", k), 32'(frm_s[k*16 +: 16]), 32'(m_frm[k]));
      end
      for (int j = 0; j < 6; j++)
         if (rd_s[j] && fq[j].size() > 0) dat_s[j*8 +: 8] = fq[j].pop_front();
      drive();
   endtask

   task automatic wait_rd(input int k, input int budget,
                          output int ch, output int lat);
      logic [2:0] r;
      ch  = -1;
      lat = 0;
      r   = '0;
      while (r == 3'b000 && lat < budget) begin
         tick();
         lat++;
         r = rd_s[k*3 +: 3];
      end
      for (int i = 0; i < 3; i++)
         if (r == (3'b001 << i)) ch = i;
      chk("rd_seen", 32'(r != 3'b000), 32'd1);
   endtask

   task automatic wait_idle(input int k, input int budget);
      int n;
      n = 0;
      while (busy_s[k] && n < budget) begin
         tick();
         n++;
      end
      chk("idle_seen", 32'(busy_s[k]), 32'd0);
   endtask

   initial begin
      int         ch;
      int         lat;
      int         n;
      int         sum;
      logic [12:0] seq;
      logic       b[52];
      logic [12:0] got_f;
      logic [12:0] exp_f;

      #1 rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // single packet from ch1 carrying 0xA5
      push(0, 1, 8'hA5);
      push(0, 1, 8'h3C);
      start_s[0] = 1'b1;
      wait_rd(0, 20, ch, lat);
      chk("A_rd", 32'(rd_s[2:0]), 32'b010);
      tick();
      seq = '0;
      repeat (13) begin
         tick();
         seq = {seq[11:0], tx_s[0]};
      end
      chk("A_seq", 32'(seq), 32'b0101010010111);
      tick();
      chk("A_frm", 32'(frm_s[15:0]), 32'd1);
      start_s[0] = 1'b0;
      tick();

      // round-robin from reset, three channels at count 5
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int j = 0; j < 6; j++) fq[j].delete();
      for (int i = 0; i < 3; i++)
         repeat (5) push(0, i, 8'($urandom));
      start_s[0] = 1'b1;
      for (int p = 0; p < 6; p++) begin
         wait_rd(0, 40, ch, lat);
         chk("B_gnt", 32'(ch), 32'(p % 3));
         if (p > 0) chk("B_per", 32'(lat), 32'd16);
      end
      start_s[0] = 1'b0;
      wait_idle(0, 60);

      // fixed priority with ch0 kept eligible
      prio_s[0] = 1'b1;
      repeat (6) push(0, 0, 8'($urandom));
      start_s[0] = 1'b1;
      for (int p = 0; p < 5; p++) begin
         wait_rd(0, 40, ch, lat);
         chk("C_gnt", 32'(ch), 32'd0);
      end
      start_s[0] = 1'b0;
      wait_idle(0, 60);
      chk("C_ch1", 32'(fq[1].size()), 32'd3);
      chk("C_ch2", 32'(fq[2].size()), 32'd3);
      prio_s[0] = 1'b0;

      // threshold 3 and 4-clock bits on the second transmitter
      push(1, 2, 8'h5A);
      push(1, 2, 8'hC3);
      start_s[1] = 1'b1;
      n = 0;
      repeat (12) begin
         tick();
         if (rd_s[5:3] != 3'b000) n++;
      end
      chk("D_nopop", 32'(n), 32'd0);
      push(1, 2, 8'h0F);
      wait_rd(1, 5, ch, lat);
      chk("D_lat", 32'(lat), 32'd1);
      chk("D_ch", 32'(ch), 32'd2);
      start_s[1] = 1'b0;
      tick();
      for (int j = 0; j < 52; j++) begin
         tick();
         b[j] = tx_s[1];
      end
      n = 0;
      for (int j = 0; j < 52; j++)
         if (b[j] != b[j - (j % 4)]) n++;
      chk("D_hold", 32'(n), 32'd0);
      for (int j = 0; j < 13; j++) begin
         got_f[j] = b[j*4 + 1];
         exp_f[j] = fbit(2'd2, 8'h5A, j);
      end
      chk("D_bits", 32'(got_f), 32'(exp_f));
      wait_idle(1, 20);

      // start dropped during the data bits
      sum = fq[0].size() + fq[1].size() + fq[2].size();
      start_s[0] = 1'b1;
      wait_rd(0, 10, ch, lat);
      repeat (6) tick();
      start_s[0] = 1'b0;
      wait_idle(0, 30);
      n = 0;
      repeat (40) begin
         tick();
         if (rd_s[2:0] != 3'b000) n++;
      end
      chk("E_nopop", 32'(n), 32'd0);
      chk("E_left", 32'(fq[0].size() + fq[1].size() + fq[2].size()),
          32'(sum - 1));

      // random traffic on both transmitters
      start_s = 2'b11;
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(63) == 0) start_s[k] = ~start_s[k];
            if ($urandom_range(127) == 0) prio_s[k] = ~prio_s[k];
            if ($urandom_range(3) == 0) begin
               n = $urandom_range(2);
               if (fq[k*3 + n].size() < 12) push(k, n, 8'($urandom));
            end
         end
      end
      start_s = 2'b00;
      wait_idle(0, 80);
      wait_idle(1, 80);

      // asynchronous reset in the middle of a frame
      prio_s[0] = 1'b0;
      repeat (3) push(0, 0, 8'($urandom));
      repeat (3) push(0, 1, 8'($urandom));
      start_s[0] = 1'b1;
      n = 0;
      while (m_t[0] < 6 && n < 80) begin
         tick();
         n++;
      end
      chk("G_inframe", 32'(m_t[0] >= 6), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("G_tx", 32'(tx_s[0]), 32'd1);
      chk("G_busy", 32'(busy_s[0]), 32'd0);
      chk("G_frm", 32'(frm_s[15:0]), 32'd0);
      chk("G_rd", 32'(rd_s[2:0]), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      wait_rd(0, 10, ch, lat);
      chk("G_first", 32'(ch), 32'd0);
      start_s[0] = 1'b0;
      wait_idle(0, 30);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
